// File: rtl/intra_pkg.sv
// Shared types and width helpers for the intra prediction mode selector.
// The FSM state type is exported so checkers can bind to the debug state port.
package intra_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_STREAM  = 2'd2
  } intra_state_e;

  localparam int FALLBACK_MODE_DEFAULT = 2;

  function automatic int MODE_W(input int num_modes);
    return (num_modes > 1) ? $clog2(num_modes) : 1;
  endfunction

  function automatic int MBNUM_W(input int frame_mbs);
    return (frame_mbs > 1) ? $clog2(frame_mbs) : 1;
  endfunction

endpackage

// File: rtl/intra_mode_table.sv
// Per-macroblock chosen-mode table: one write port, one registered read port.
// Contents are never reset; only the read register is.
module intra_mode_table
  import intra_pkg::*;
#(
  parameter int DEPTH  = 14400,
  parameter int DATA_W = 4,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              waddr_ok;
  logic              raddr_ok;

  assign waddr_ok = ({1'b0, waddr_i} < DEPTH_L);
  assign raddr_ok = ({1'b0, raddr_i} < DEPTH_L);

  always_ff @(posedge clk_i) begin
    if (we_i && waddr_ok) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of mem gives read-old-data on a same-address write.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= raddr_ok ? mem[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/intra_mode_selector.sv
// Picks the lowest-SAD enabled intra mode for a macroblock, records it in the
// mode table and streams that mode's residue block out one row per beat.
module intra_mode_selector
  import intra_pkg::*;
#(
  parameter int NUM_MODES     = 9,
  parameter int MB_L          = 8,
  parameter int MB_W          = 8,
  parameter int SAD_W         = 16,
  parameter int FRAME_MBS     = 14400,
  parameter int FALLBACK_MODE = FALLBACK_MODE_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_MODES*SAD_W-1:0]           sads,
  input  logic [NUM_MODES*MB_L*MB_W*8-1:0]     residues,
  input  logic [NUM_MODES-1:0]                 mode_mask,
  input  logic [MBNUM_W(FRAME_MBS)-1:0]        mbnumber,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [MB_W*8-1:0]                    out_res,
  output logic [$clog2(MB_L)-1:0]              out_row,
  output logic                                 out_last,
  output logic [MODE_W(NUM_MODES)-1:0]         out_mode,
  output logic [SAD_W-1:0]                     out_sad,
  output logic [MBNUM_W(FRAME_MBS)-1:0]        out_mbnumber,
  input  logic [MBNUM_W(FRAME_MBS)-1:0]        rd_mbnumber,
  output logic [MODE_W(NUM_MODES)-1:0]         rd_mode,
  output logic                                 err_nomode,
  output intra_state_e                         dbg_state_o
);

  localparam int MW   = MODE_W(NUM_MODES);
  localparam int NW   = MBNUM_W(FRAME_MBS);
  localparam int RW   = $clog2(MB_L);
  localparam int CW   = $clog2(NUM_MODES + 1);
  localparam int ROWB = MB_W * 8;
  localparam logic [MW-1:0] FB_MODE = MW'(FALLBACK_MODE);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never waits on ready, and a source holds valid and payload stable
  // until the transfer occurs.

  intra_state_e state_q, state_d;

  logic [NUM_MODES*SAD_W-1:0]       sads_q;
  logic [NUM_MODES*MB_L*ROWB-1:0]   res_q;
  logic [NUM_MODES-1:0]             mask_q;
  logic [NW-1:0]                    mbnum_q;

  logic [CW-1:0]    idx_q, idx_d;
  logic             found_q, found_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [MW-1:0]    best_mode_q, best_mode_d;

  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [RW-1:0]    out_row_q, out_row_d;
  logic [MW-1:0]    out_mode_q, out_mode_d;
  logic [SAD_W-1:0] out_sad_q, out_sad_d;
  logic [NW-1:0]    out_mbnum_q, out_mbnum_d;
  logic [ROWB-1:0]  out_res_q, out_res_d;
  logic             err_q, err_d;

  logic             in_fire;
  logic [SAD_W-1:0] cur_sad;
  logic             cur_en;
  logic [MW-1:0]    final_mode;
  logic [SAD_W-1:0] final_sad;
  logic [MW-1:0]    ld_mode;
  logic [RW-1:0]    ld_row;
  logic [RW-1:0]    next_row;
  logic [ROWB-1:0]  row_data;
  logic             tbl_we;

  assign in_ready = (state_q == ST_IDLE);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (in_fire) begin
      sads_q  <= sads;
      res_q   <= residues;
      mask_q  <= mode_mask;
      mbnum_q <= mbnumber;
    end
  end

  always_comb begin
    cur_sad = '0;
    cur_en  = 1'b0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (idx_q == CW'(k)) begin
        cur_sad = sads_q[k*SAD_W +: SAD_W];
        cur_en  = mask_q[k];
      end
    end
  end

  assign final_mode = found_q ? best_mode_q : FB_MODE;
  assign final_sad  = found_q ? best_sad_q : '1;
  assign next_row   = out_row_q + RW'(1);

  // Row loaded at COMPARE exit is row 0 of the winner; afterwards the next row.
  assign ld_mode = (state_q == ST_STREAM) ? out_mode_q : final_mode;
  assign ld_row  = (state_q == ST_STREAM) ? next_row : '0;

  always_comb begin
    row_data = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      for (int r = 0; r < MB_L; r++) begin
        if (ld_mode == MW'(k) && ld_row == RW'(r)) begin
          row_data = res_q[(k*MB_L + r)*ROWB +: ROWB];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    found_d     = found_q;
    best_sad_d  = best_sad_q;
    best_mode_d = best_mode_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_row_d   = out_row_q;
    out_mode_d  = out_mode_q;
    out_sad_d   = out_sad_q;
    out_mbnum_d = out_mbnum_q;
    out_res_d   = out_res_q;
    err_d       = 1'b0;
    tbl_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          idx_d       = '0;
          found_d     = 1'b0;
          best_sad_d  = '0;
          best_mode_d = '0;
          state_d     = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        // idx == NUM_MODES is the resolve cycle after the last examined mode.
        if (idx_q == CW'(NUM_MODES)) begin
          tbl_we      = 1'b1;
          err_d       = !found_q;
          out_valid_d = 1'b1;
          out_row_d   = '0;
          out_last_d  = (MB_L == 1);
          out_mode_d  = final_mode;
          out_sad_d   = final_sad;
          out_mbnum_d = mbnum_q;
          out_res_d   = row_data;
          state_d     = ST_STREAM;
        end else begin
          if (cur_en && (!found_q || cur_sad < best_sad_q)) begin
            found_d     = 1'b1;
            best_sad_d  = cur_sad;
            best_mode_d = MW'(idx_q);
          end
          idx_d = idx_q + CW'(1);
        end
      end

      ST_STREAM: begin
        if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            out_row_d  = next_row;
            out_last_d = (next_row == RW'(MB_L - 1));
            out_res_d  = row_data;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      found_q     <= 1'b0;
      best_sad_q  <= '0;
      best_mode_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_mode_q  <= '0;
      out_sad_q   <= '0;
      out_mbnum_q <= '0;
      out_res_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      best_sad_q  <= best_sad_d;
      best_mode_q <= best_mode_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_row_q   <= out_row_d;
      out_mode_q  <= out_mode_d;
      out_sad_q   <= out_sad_d;
      out_mbnum_q <= out_mbnum_d;
      out_res_q   <= out_res_d;
      err_q       <= err_d;
    end
  end

  intra_mode_table #(
    .DEPTH  (FRAME_MBS),
    .DATA_W (MW),
    .ADDR_W (NW)
  ) u_table (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (tbl_we),
    .waddr_i (mbnum_q),
    .wdata_i (final_mode),
    .raddr_i (rd_mbnumber),
    .rdata_o (rd_mode)
  );

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_row      = out_row_q;
  assign out_mode     = out_mode_q;
  assign out_sad      = out_sad_q;
  assign out_mbnumber = out_mbnum_q;
  assign out_res      = out_res_q;
  assign err_nomode   = err_q;
  assign dbg_state_o  = state_q;

endmodule
